// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    // Fetch sequencing: request a word, wait for it, hand it to decode, or stop.
    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    // Reason the unit parked itself; NONE until the first fault after reset.
    typedef enum logic [1:0] {
        NONE       = 2'd0,
        MISALIGNED = 2'd1,
        ACCESS     = 2'd2
    } fetch_fault_cause_t;

    localparam logic [31:0] FETCH_RESET_PC_DEFAULT = 32'h0000_0000;

    // Byte distance between consecutive sequential instructions.
    localparam logic [31:0] FETCH_WORD_BYTES = 32'd4;

    // A fetch address is usable only if it points at a whole 32-bit word.
    function automatic logic fetch_is_aligned(input logic [1:0] addr_lo);
        return (addr_lo == 2'b00);
    endfunction

endpackage : fetch_pkg

// File: rtl/instructions_pkg.sv
// Instruction-side shared types. The decoder consumes instr_packet directly,
// so the fetch unit hands over the raw 32-bit instruction word.
package instructions_pkg;

    typedef logic [31:0] instr_packet;

endpackage : instructions_pkg

// File: rtl/fetch_next_pc.sv
// Next-PC selection for the fetch unit: sequential increment or redirect
// target, plus a word-alignment check on whichever address wins.
module fetch_next_pc
    import fetch_pkg::*;
(
    input  logic        i_sel,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_next,
    output logic        o_misaligned
);

    logic [31:0] w_seq_pc;

    // The 32-bit add wraps naturally, so 0xFFFF_FFFC steps to 0x0000_0000.
    assign w_seq_pc     = i_pc + FETCH_WORD_BYTES;
    assign o_next       = i_sel ? i_redirect_pc : w_seq_pc;
    assign o_misaligned = !fetch_is_aligned(o_next[1:0]);

endmodule : fetch_next_pc

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one instruction-memory read at
// a time, buffers the returned word for decode and advances the PC when
// decode consumes it. Misaligned targets and memory errors park the unit in a
// sticky fault state that only reset clears.
module fetch_unit
    import fetch_pkg::*;
    import instructions_pkg::*;
#(
    // Must be word aligned; it is loaded into the PC as-is.
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC_DEFAULT
)
(
    input  logic               clock,
    input  logic               reset,

    // Instruction-memory request channel
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [31:0]        imem_req_addr,

    // Instruction-memory response channel
    input  logic               imem_rsp_valid,
    input  logic [31:0]        imem_rsp_data,
    input  logic               imem_rsp_error,

    // Decode-side instruction channel
    output instr_packet        instr,
    output logic [31:0]        instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               pc_input_sel,
    input  logic [31:0]        redirect_pc,

    // Sticky fault reporting
    output logic               fetch_fault,
    output fetch_fault_cause_t fetch_fault_cause,
    output logic [31:0]        fetch_fault_pc
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    fetch_state_t       r_state;
    fetch_state_t       w_state_next;

    logic [31:0]        r_pc;
    logic [31:0]        w_pc_next;

    instr_packet        r_instr;
    logic [31:0]        r_instr_pc;
    logic               w_load_instr;

    // Set when reset interrupts an outstanding read: that read's response
    // still arrives later and must not be mistaken for a fresh one.
    logic               r_stale;
    logic               w_stale_next;

    fetch_fault_cause_t r_fault_cause;
    fetch_fault_cause_t w_fault_cause_next;
    logic [31:0]        r_fault_pc;
    logic [31:0]        w_fault_pc_next;

    logic [31:0]        w_next_pc;
    logic               w_next_misaligned;
    logic               w_req_fire;

    // ------------------------------------------------------------------
    // Next-PC datapath
    // ------------------------------------------------------------------
    // The PC always equals instr_pc while an instruction is held, so the
    // PC register feeds the next-PC logic directly.
    fetch_next_pc u_next_pc (
        .i_sel         (pc_input_sel),
        .i_pc          (r_pc),
        .i_redirect_pc (redirect_pc),
        .o_next        (w_next_pc),
        .o_misaligned  (w_next_misaligned)
    );

    // ------------------------------------------------------------------
    // Outputs: all decoded from registered state
    // ------------------------------------------------------------------
    assign imem_req_valid    = (r_state == REQ) && !r_stale;
    assign imem_req_addr     = r_pc;
    assign w_req_fire        = imem_req_valid && imem_req_ready;

    assign instr             = r_instr;
    assign instr_pc          = r_instr_pc;
    assign instr_valid       = (r_state == HOLD);

    assign fetch_fault       = (r_state == FAULT);
    assign fetch_fault_cause = r_fault_cause;
    assign fetch_fault_pc    = r_fault_pc;

    // ------------------------------------------------------------------
    // FSM next-state and register-update decisions
    // ------------------------------------------------------------------
    // Next state, PC, buffer load and fault capture for the current cycle.
    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_load_instr       = 1'b0;
        w_fault_cause_next = r_fault_cause;
        w_fault_pc_next    = r_fault_pc;

        unique case (r_state)
            REQ: begin
                // Responses seen here are either the stale one (handled by
                // the stale flag) or unexpected, and are ignored either way.
                if (w_req_fire) begin
                    w_state_next = WAIT;
                end
            end

            WAIT: begin
                if (imem_rsp_valid) begin
                    if (imem_rsp_error) begin
                        w_state_next       = FAULT;
                        w_fault_cause_next = ACCESS;
                        w_fault_pc_next    = r_pc;
                    end else begin
                        w_load_instr = 1'b1;
                        w_state_next = HOLD;
                    end
                end
            end

            HOLD: begin
                if (instr_ready) begin
                    if (w_next_misaligned) begin
                        // PC keeps the last good address; the bad target is
                        // reported through the fault PC instead.
                        w_state_next       = FAULT;
                        w_fault_cause_next = MISALIGNED;
                        w_fault_pc_next    = w_next_pc;
                    end else begin
                        w_pc_next    = w_next_pc;
                        w_state_next = REQ;
                    end
                end
            end

            FAULT: begin
                w_state_next = FAULT;
            end

            default: begin
                w_state_next = FAULT;
            end
        endcase
    end

    // The first response after a mid-read reset consumes the stale marker.
    always_comb begin
        w_stale_next = r_stale && !imem_rsp_valid;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // FSM state and program counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= REQ;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    // Stale-response tracking: a reset that lands while a read is still in
    // flight (and its data is not arriving this very cycle) leaves one
    // response owed by memory.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stale <= (r_state == WAIT) && !imem_rsp_valid;
        end else begin
            r_stale <= w_stale_next;
        end
    end

    // Instruction buffer presented to decode; frozen while in HOLD.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_instr    <= '0;
            r_instr_pc <= '0;
        end else if (w_load_instr) begin
            r_instr    <= imem_rsp_data;
            r_instr_pc <= r_pc;
        end
    end

    // Sticky fault cause and offending address.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fault_cause <= NONE;
            r_fault_pc    <= '0;
        end else begin
            r_fault_cause <= w_fault_cause_next;
            r_fault_pc    <= w_fault_pc_next;
        end
    end

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a behavioural memory, a randomized
// decode consumer and a transaction-level model of the expected fetch stream.
module tb_fetch_unit;
    import fetch_pkg::*;
    import instructions_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic               clock;
    logic               reset;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [31:0]        imem_req_addr;
    logic               imem_rsp_valid;
    logic [31:0]        imem_rsp_data;
    logic               imem_rsp_error;
    instr_packet        instr;
    logic [31:0]        instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic               pc_input_sel;
    logic [31:0]        redirect_pc;
    logic               fetch_fault;
    fetch_fault_cause_t fetch_fault_cause;
    logic [31:0]        fetch_fault_pc;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clock             (clock),
        .reset             (reset),
        .imem_req_valid    (imem_req_valid),
        .imem_req_ready    (imem_req_ready),
        .imem_req_addr     (imem_req_addr),
        .imem_rsp_valid    (imem_rsp_valid),
        .imem_rsp_data     (imem_rsp_data),
        .imem_rsp_error    (imem_rsp_error),
        .instr             (instr),
        .instr_pc          (instr_pc),
        .instr_valid       (instr_valid),
        .instr_ready       (instr_ready),
        .pc_input_sel      (pc_input_sel),
        .redirect_pc       (redirect_pc),
        .fetch_fault       (fetch_fault),
        .fetch_fault_cause (fetch_fault_cause),
        .fetch_fault_pc    (fetch_fault_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: what decode and memory should see, at transaction level.
    logic [31:0]        m_pc;
    bit                 m_need_req, m_wait, m_have_instr, m_stale, m_fault, m_after_reset;
    fetch_fault_cause_t m_cause;
    logic [31:0]        m_fault_pc;
    int                 fault_cycles, last_consume;

    // Behavioural single-slot instruction memory.
    bit                 mem_busy, mem_err;
    int                 mem_cnt;
    logic [31:0]        mem_addr;

    // Stimulus knobs and one-shot directed overrides.
    int k_ready_pct, k_dmax, k_iready_pct, k_sel_pct, k_mis_pct, k_err_pct, k_spur_pct, k_rst_pm;
    bit k_auto_reset, k_check_rate;
    bit f_reset_now, f_rst_busy, f_redir_en, f_err_en;
    logic [31:0] f_redir_at, f_redir_to, f_err_at;
    int f_ready_low, f_iready_low, f_delay;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // Observe the current cycle, choose the inputs for it, advance the model
    // to the following cycle, then move to just after the next rising edge.
    task automatic step();
        bit do_rst, waiting, rsp_now, rsp_err, rdy, iready, sel, forced, consume, accept;
        logic [31:0] redir, nxt;

        if (m_after_reset) begin
            check("reset_instr", instr, 32'h0);
            m_after_reset = 0;
        end
        check("fault_flag", 32'(fetch_fault), 32'(m_fault));
        check("fault_cause", 32'(fetch_fault_cause), 32'(m_cause));
        check("fault_pc", fetch_fault_pc, m_fault_pc);
        check("req_valid", 32'(imem_req_valid), 32'(m_need_req));
        if (imem_req_valid) check("req_addr", imem_req_addr, m_pc);
        check("instr_valid", 32'(instr_valid), 32'(m_have_instr));
        if (instr_valid) begin
            check("instr_pc", instr_pc, m_pc);
            check("instr_word", instr, mem_word(m_pc));
        end

        do_rst = f_reset_now || (f_rst_busy && m_wait) ||
                 (k_auto_reset && m_fault && fault_cycles >= 3) ||
                 (int'($urandom % 1000) < k_rst_pm);
        if (f_rst_busy && m_wait) f_rst_busy = 0;
        f_reset_now = 0;
        if (m_fault) fault_cycles++;
        waiting = m_wait;
        reset = do_rst;

        // Memory response side
        rsp_now = 0;
        rsp_err = 0;
        imem_rsp_data = $urandom;
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                rsp_now = 1;
                rsp_err = mem_err;
                imem_rsp_data = mem_word(mem_addr);
                mem_busy = 0;
            end else begin
                mem_cnt--;
            end
        end else if (int'($urandom % 100) < k_spur_pct) begin
            rsp_now = 1;
            rsp_err = ($urandom_range(1, 0) == 1);
        end
        imem_rsp_valid = rsp_now;
        imem_rsp_error = rsp_err;

        // Memory request side: one outstanding read at most
        rdy = (int'($urandom % 100) < k_ready_pct) && !mem_busy;
        if (f_ready_low > 0) begin
            rdy = 0;
            f_ready_low--;
        end
        imem_req_ready = rdy;
        accept = !do_rst && imem_req_valid && rdy;
        if (accept) begin
            mem_busy = 1;
            mem_addr = imem_req_addr;
            mem_cnt  = (f_delay >= 0) ? f_delay : int'($urandom_range(k_dmax, 0));
            if (f_err_en && imem_req_addr == f_err_at) begin
                mem_err  = 1;
                f_err_en = 0;
            end else begin
                mem_err = (int'($urandom % 100) < k_err_pct);
            end
        end

        // Decode side
        iready = (int'($urandom % 100) < k_iready_pct);
        if (f_iready_low > 0 && m_have_instr) begin
            iready = 0;
            f_iready_low--;
        end
        forced = f_redir_en && (m_pc == f_redir_at);
        if (forced) begin
            sel   = 1;
            redir = f_redir_to;
        end else begin
            sel   = (int'($urandom % 100) < k_sel_pct);
            redir = $urandom & 32'hFFFF_FFFC;
            if (int'($urandom % 100) < k_mis_pct) redir[1:0] = 2'($urandom_range(3, 1));
        end
        instr_ready  = iready;
        pc_input_sel = sel;
        redirect_pc  = redir;
        consume = !do_rst && instr_valid && iready;

        // Model advance
        if (do_rst) begin
            m_stale       = waiting && !rsp_now;
            m_wait        = 0;
            m_pc          = RST_PC;
            m_need_req    = !m_stale;
            m_have_instr  = 0;
            m_fault       = 0;
            m_cause       = NONE;
            m_fault_pc    = 32'h0;
            m_after_reset = 1;
            fault_cycles  = 0;
            last_consume  = -1;
            $display("cycle %0d reset stale_expected=%0d", cyc, m_stale);
        end else begin
            if (rsp_now) begin
                if (m_stale) begin
                    m_stale    = 0;
                    m_need_req = 1;
                end else if (waiting) begin
                    m_wait = 0;
                    if (rsp_err) begin
                        m_fault    = 1;
                        m_cause    = ACCESS;
                        m_fault_pc = m_pc;
                        $display("cycle %0d access error at %08h", cyc, m_pc);
                    end else begin
                        m_have_instr = 1;
                    end
                end
            end
            if (accept) begin
                m_wait     = 1;
                m_need_req = 0;
            end
            if (consume) begin
                nxt = sel ? redir : m_pc + 32'd4;
                m_have_instr = 0;
                if (forced) f_redir_en = 0;
                if (k_check_rate && last_consume >= 0) check("consume_gap", 32'(cyc - last_consume), 32'd3);
                last_consume = cyc;
                $display("cycle %0d consume pc=%08h instr=%08h sel=%0d next=%08h", cyc, m_pc, instr, sel, nxt);
                if (nxt[1:0] != 2'b00) begin
                    m_fault    = 1;
                    m_cause    = MISALIGNED;
                    m_fault_pc = nxt;
                end else begin
                    m_pc       = nxt;
                    m_need_req = 1;
                end
            end
        end

        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_error = 1'b0;
        instr_ready    = 1'b0;
        pc_input_sel   = 1'b0;
        redirect_pc    = 32'h0;

        m_pc = RST_PC; m_need_req = 1; m_wait = 0; m_have_instr = 0; m_stale = 0;
        m_fault = 0; m_cause = NONE; m_fault_pc = 32'h0; m_after_reset = 1;
        fault_cycles = 0; last_consume = -1;
        mem_busy = 0; mem_err = 0; mem_cnt = 0; mem_addr = 32'h0;

        // Zero-wait memory, always-ready decode, sequential flow
        k_ready_pct = 100; k_dmax = 0; k_iready_pct = 100; k_sel_pct = 0;
        k_mis_pct = 0; k_err_pct = 0; k_spur_pct = 0; k_rst_pm = 0;
        k_auto_reset = 0; k_check_rate = 1;
        f_reset_now = 0; f_rst_busy = 0; f_err_en = 0; f_err_at = 32'h0;
        f_ready_low = 0; f_iready_low = 0; f_delay = -1;

        repeat (2) @(posedge clock);
        #1;

        // Sequential fetch from 0x100 then redirect at 0x104 to 0x2000
        f_redir_en = 1; f_redir_at = 32'h104; f_redir_to = 32'h2000;
        run(15);

        // Misaligned redirect target
        f_redir_en = 1; f_redir_at = 32'h2010; f_redir_to = 32'h2002;
        run(12);

        // Access error on the read of 0x108; unit must stay parked
        f_reset_now = 1; f_err_en = 1; f_err_at = 32'h108;
        run(16);

        // Back-pressure on both channels
        k_check_rate = 0;
        f_reset_now = 1; f_ready_low = 6;
        run(14);
        f_iready_low = 4;
        run(14);

        // Reset while a read is outstanding; its late response must be dropped
        f_reset_now = 1;
        run(1);
        f_delay = 2; f_rst_busy = 1;
        run(12);
        f_delay = -1;

        // Wrap-around of the sequential PC
        k_check_rate = 1;
        f_reset_now = 1; f_redir_en = 1; f_redir_at = 32'h104; f_redir_to = 32'hFFFF_FFFC;
        run(15);

        // Randomized traffic
        k_check_rate = 0;
        k_ready_pct = 70; k_dmax = 3; k_iready_pct = 60; k_sel_pct = 25;
        k_mis_pct = 5; k_err_pct = 3; k_spur_pct = 5; k_rst_pm = 5; k_auto_reset = 1;
        run(4000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fetch_unit
